// File: rtl/divider64b_seq.sv
// divider64b_seq: sequential 64-bit restoring divider for the RV64M execute stage.
// A single engine serves signed and unsigned division and yields quotient and
// remainder together, one quotient bit per clock. Divide-by-zero and signed
// overflow bypass the iteration and resolve in one extra edge.
//
// Handshake: a request is accepted on a rising edge where start=1 and busy=0
// (state IDLE or DONE). Operands and SIGNED are captured on that edge only and
// may change freely afterwards. done pulses for one cycle when Q/R become valid;
// Q/R then hold until the FIX edge of the next accepted request.
module divider64b_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        SIGNED,
  input  logic [63:0] A,
  input  logic [63:0] B,
  output logic        busy,
  output logic        done,
  output logic [63:0] Q,
  output logic [63:0] R,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN_NEG  = 64'h8000_0000_0000_0000;

  logic [1:0]  state;
  logic [5:0]  cnt;       // iteration counter, 63 down to 0
  logic        sgn;       // captured SIGNED
  logic        sa;        // captured sign of dividend
  logic        sb;        // captured sign of divisor
  logic        special;   // result was preloaded, skip sign fix-up
  logic [63:0] dvd;       // dividend shifting out, quotient shifting in
  logic [63:0] dvs;       // divisor magnitude
  logic [63:0] rem;       // partial remainder

  logic [63:0] abs_a;
  logic [63:0] abs_b;
  logic [64:0] rem_sh;
  logic [64:0] trial;
  logic        trial_ok;
  logic        is_div0;
  logic        is_ovf;
  logic [63:0] q_fix;
  logic [63:0] r_fix;

  // Operand magnitudes and special-case detection for the accepting edge
  always_comb begin
    abs_a   = (SIGNED && A[63]) ? (~A + 64'd1) : A;
    abs_b   = (SIGNED && B[63]) ? (~B + 64'd1) : B;
    is_div0 = (B == 64'd0);
    is_ovf  = SIGNED && (A == MIN_NEG) && (B == ALL_ONES);
  end

  // One restoring step: shift {rem, dvd} left, trial-subtract the divisor.
  // rem < dvs always holds, so rem_sh < 2^65 and bit 64 of the 65-bit trial
  // is a reliable sign bit.
  always_comb begin
    rem_sh   = {rem, dvd[63]};
    trial    = rem_sh - {1'b0, dvs};
    trial_ok = ~trial[64];
  end

  // Final sign correction: quotient sign is sa^sb, remainder follows dividend
  always_comb begin
    q_fix = dvd;
    r_fix = rem;
    if (sgn && !special) begin
      if (sa ^ sb) q_fix = ~dvd + 64'd1;
      if (sa)      r_fix = ~rem + 64'd1;
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      sgn     <= 1'b0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      special <= 1'b0;
      dvd     <= 64'd0;
      dvs     <= 64'd0;
      rem     <= 64'd0;
      done    <= 1'b0;
      Q       <= 64'd0;
      R       <= 64'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sgn <= SIGNED;
            sa  <= A[63];
            sb  <= B[63];
            dvs <= abs_b;
            cnt <= 6'd63;
            if (is_div0) begin
              special <= 1'b1;
              dvd     <= ALL_ONES;
              rem     <= A;
              state   <= FIX;
            end else if (is_ovf) begin
              special <= 1'b1;
              dvd     <= A;
              rem     <= 64'd0;
              state   <= FIX;
            end else begin
              special <= 1'b0;
              dvd     <= abs_a;
              rem     <= 64'd0;
              state   <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          dvd <= {dvd[62:0], trial_ok};
          rem <= trial_ok ? trial[63:0] : rem_sh[63:0];
          if (cnt == 6'd0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        FIX: begin
          Q     <= q_fix;
          R     <= r_fix;
          done  <= 1'b1;
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // busy covers the in-flight states only; DONE can accept a new request
  always_comb begin
    busy      = (state == RUN) || (state == FIX);
    dbg_state = state;
  end

endmodule

// File: tb/tb_divider64b_seq.sv
// tb_divider64b_seq: scoreboard bench for divider64b_seq.
module tb_divider64b_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        SIGNED;
  logic [63:0] A;
  logic [63:0] B;
  logic        busy;
  logic        done;
  logic [63:0] Q;
  logic [63:0] R;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  divider64b_seq dut (
    .clk(clk), .reset(reset), .start(start), .SIGNED(SIGNED),
    .A(A), .B(B), .busy(busy), .done(done), .Q(Q), .R(R),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference: RISC-V division semantics from language operators
  function automatic logic [127:0] model(input bit s, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] as_, bs_;
    logic [63:0] q, r;
    as_ = a;
    bs_ = b;
    if (b == 64'd0) begin
      q = '1;
      r = a;
    end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q = a;
      r = 64'd0;
    end else if (s) begin
      q = as_ / bs_;
      r = as_ % bs_;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  function automatic int exp_lat(input bit s, input logic [63:0] a, input logic [63:0] b);
    if (b == 64'd0) return 1;
    if (s && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
    return 65;
  endfunction

  // scoreboard: every done pulse pops and compares one expected result
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        chk("q", Q, e[127:64]);
        chk("r", R, e[63:0]);
      end
    end
  end

  // driver: presents a request now; the next rising edge accepts it.
  // pulse_at>0 injects a competing start that many edges after acceptance.
  task automatic run_op(input bit s, input logic [63:0] a, input logic [63:0] b, input int pulse_at);
    int cyc;
    SIGNED = s;
    A = a;
    B = b;
    start = 1'b1;
    exp_q.push_back(model(s, a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    A = {$urandom, $urandom};
    B = {$urandom, $urandom};
    SIGNED = $urandom_range(0, 1);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == pulse_at) begin
        start = 1'b1;
        A = 64'd1000;
        B = 64'd3;
      end else begin
        start = 1'b0;
      end
    end while (!done && cyc < 200);
    chk("latency", 64'(cyc), 64'(exp_lat(s, a, b)));
    chk("busy_at_done", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    SIGNED = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_q", Q, 64'd0);
    chk("rst_r", R, 64'd0);
    chk("rst_state", {62'd0, dbg_state}, 64'd0);
    // start together with reset must not be accepted
    start = 1'b1;
    A = 64'd9;
    B = 64'd3;
    @(posedge clk);
    #1;
    chk("start_in_reset", {63'd0, busy}, 64'd0);
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_reset", {63'd0, busy}, 64'd0);

    @(negedge clk); run_op(1'b0, 64'd100, 64'd7, 0);
    @(negedge clk); run_op(1'b1, -64'sd7, 64'd2, 0);
    @(negedge clk); run_op(1'b1, 64'd7, -64'sd2, 0);
    @(negedge clk); run_op(1'b0, 64'd5, 64'd0, 0);
    @(negedge clk); run_op(1'b1, 64'd5, 64'd0, 0);
    @(negedge clk); run_op(1'b1, 64'h8000_0000_0000_0000, '1, 0);
    @(negedge clk); run_op(1'b0, 64'h8000_0000_0000_0000, '1, 0);
    @(negedge clk); run_op(1'b1, -64'sd7, -64'sd2, 0);
    @(negedge clk); run_op(1'b0, '1, 64'd1, 0);

    // competing start at iteration 10 is ignored
    @(negedge clk); run_op(1'b0, 64'd123456789, 64'd1000, 10);

    // start in the DONE cycle is accepted back-to-back
    run_op(1'b1, -64'sd1000001, 64'd77, 0);
    run_op(1'b0, 64'hDEAD_BEEF_0000_1234, 64'h1_0000, 0);

    // randomized operands in both modes
    for (int i = 0; i < 12; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = (i % 3 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom} >> $urandom_range(0, 63);
      @(negedge clk);
      run_op(i[0], ra, rb, 0);
    end

    // reset at iteration 30 aborts with no done pulse
    @(negedge clk);
    SIGNED = 1'b0;
    A = 64'd999;
    B = 64'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_q", Q, 64'd0);
    chk("abort_r", R, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    chk("abort_idle", {62'd0, dbg_state}, 64'd0);

    // normal operation resumes after the abort
    @(negedge clk); run_op(1'b1, -64'sd100, 64'd7, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time bound
  initial begin
    #500000;
    $display("FAIL timeout got=%0d exp=0", 1);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
